vga_layer_scheduler: RTL and testbench
======================================

Name: vga_layer_scheduler

Overview:
Pixel-timing sequencer and layer arbiter for the 1-bit-per-colour VGA output on the MKR D header. It runs on the 120 MHz system clock and derives a pixel strobe from it. It generates 640x480 timing and publishes the current pixel coordinate to NUM_LAYERS game-object layers. It then selects the highest-priority visible layer colour and drives registered RGB/HSYNC/VSYNC, replacing ad-hoc AND/OR merging of per-object outputs.

Parameters:
CLK_DIV, 5, system clocks per pixel (120 MHz / 5 = 24 MHz pixel rate); legal 2..15
NUM_LAYERS, 4, number of object layers; index 0 = highest priority; legal 1..8
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_NEG, 1, 1 = sync pulses active-low

Ports:
iCLK  in  1  system clock (120 MHz)
iRESET  in  1  asynchronous reset, active-high
iENABLE  in  1  run timing; low = blank and hold at origin
iBG_RGB  in  3  background colour {R,G,B}
iLAYER_VALID  in  NUM_LAYERS  per-layer "pixel opaque at presented coordinate"
iLAYER_RGB  in  3*NUM_LAYERS  per-layer colour, layer n at bits [3n+2:3n]
oPIX_EN  out  1  one-clock pixel strobe
oX  out  10  coordinate being requested from layers
oY  out  10  line being requested from layers
oACTIVE  out  1  oX/oY inside visible area
oFRAME_START  out  1  one-clock pulse at coordinate (0,0)
oVBLANK  out  1  high while vcnt >= V_ACTIVE (safe object-update window)
oRED, oGREEN, oBLUE  out  1 each  pixel colour to pins
oHSYNC, oVSYNC  out  1 each  sync to pins

Behaviour:
- Reset (async, immediate): divider, hcnt and vcnt = 0. oPIX_EN, oFRAME_START, oACTIVE, oVBLANK, oX, oY and RGB = 0. oHSYNC/oVSYNC = inactive level (1 when SYNC_NEG = 1).
- Divider: counts 0..CLK_DIV-1 while iENABLE. oPIX_EN is high on the clock where the divider equals CLK_DIV-1.
- On each oPIX_EN, hcnt advances. It wraps at H_TOTAL-1 to 0 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800) and vcnt increments on that wrap. vcnt wraps at V_TOTAL-1 to 0 (V_TOTAL = 525).
- oX/oY are registered copies of hcnt/vcnt, updated on the oPIX_EN clock. Widths are 10 bits; parameters must keep H_TOTAL and V_TOTAL at or below 1024.
- oACTIVE = (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE).
- oFRAME_START is pulsed for one clock when hcnt = vcnt = 0 is entered.
- oVBLANK follows vcnt with no pipeline delay.
- Layer contract: each layer must present iLAYER_VALID/iLAYER_RGB for (oX,oY) no later than the next oPIX_EN. Layers may register their result.
- Arbitration (sampled on oPIX_EN, applied to the previous coordinate):
  - selected colour = iLAYER_RGB of the lowest index n with iLAYER_VALID[n] = 1;
  - otherwise iBG_RGB;
  - forced to 000 if that coordinate was not active.
- Sync generation: HSYNC is at active level when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; VSYNC uses the same rule on vcnt. Both are delayed one pixel period so they stay aligned with RGB.
- Latency: coordinate issued on oPIX_EN k → pin outputs updated on oPIX_EN k+1 (CLK_DIV clocks). All pin outputs are flops.
- Simultaneous events: the last pixel of the last line wraps both counters on the same strobe and pulses oFRAME_START on that strobe's following coordinate (0,0).
- iENABLE low (any time, mid-line allowed): takes effect on the next clock.
  - Divider, hcnt and vcnt are cleared; oPIX_EN stays 0.
  - RGB forced to 000 and syncs forced inactive.
  - Re-enable starts at (0,0). The first oPIX_EN occurs CLK_DIV clocks after iENABLE rises, with oFRAME_START on it.
- Reset mid-frame: identical to power-up reset; no partial-frame state survives.
- X/Z on unused layer inputs is not permitted; tie them low.

Decomposition:
- Package vga_pkg: the default 640x480 timing constants, the derived H_TOTAL/V_TOTAL, the RGB width constant (3), and an rgb_t 3-bit typedef.
- Sub-module vga_layer_mux: a combinational priority select over NUM_LAYERS plus background and blank forcing. It is instantiated once; the top holds the counters and the pipeline flops.

Test Plan:
1. Reset, then iENABLE = 1 for 2 frames → oPIX_EN period is exactly 5 clocks. Line = 800 strobes, frame = 525 lines; oFRAME_START every 420000 strobes.
2. Sync timing → oHSYNC is low exactly for hcnt 656..751 (96 strobes) delayed one pixel, and high otherwise. oVSYNC is low for lines 490..491. oVBLANK is high for lines 480..524.
3. Layers 0 and 2 both valid at (100,50), with RGB 100 and 011 → pins show 100 one pixel after (100,50) is issued. Drop layer 0 → 011. No layer valid with iBG_RGB = 001 → 001.
4. All layers valid with 111 at hcnt = 700 (horizontal blank) → pins 000 while syncs still toggle.
5. Deassert iENABLE at (320,200), hold 10 clocks, reassert → RGB = 000 and syncs inactive the clock after deassert. The first oPIX_EN comes 5 clocks after re-enable with oX = oY = 0 and oFRAME_START = 1.
6. Assert iRESET asynchronously mid-line, between clock edges → all outputs at reset values before the next iCLK edge. Release → the same sequence as scenario 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480 VGA timing constants and the shared colour type.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int RGB_W        = 3;

  typedef logic [RGB_W-1:0] rgb_t;
endpackage

// File: rtl/vga_layer_mux.sv
// Combinational layer arbiter: lowest-index opaque layer wins, else background;
// blanked to black outside the visible area.
module vga_layer_mux
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]       layer_valid,
  input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
  input  rgb_t                        bg_rgb,
  input  logic                        active,
  output rgb_t                        pix_rgb
);

  always_comb begin
    pix_rgb = bg_rgb;
    // Walk from lowest priority upward so the lowest valid index is written last.
    for (int n = NUM_LAYERS - 1; n >= 0; n--) begin
      if (layer_valid[n]) pix_rgb = layer_rgb[RGB_W*n +: RGB_W];
    end
    if (!active) pix_rgb = '0;
  end

endmodule

// File: rtl/vga_layer_scheduler.sv
// VGA pixel-timing sequencer and layer arbiter; coordinate issued on strobe k
// reaches the registered RGB/sync pins on strobe k+1.
module vga_layer_scheduler
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int NUM_LAYERS = 4,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_NEG   = 1
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic                        iENABLE,
  input  logic [RGB_W-1:0]            iBG_RGB,
  input  logic [NUM_LAYERS-1:0]       iLAYER_VALID,
  input  logic [RGB_W*NUM_LAYERS-1:0] iLAYER_RGB,
  output logic                        oPIX_EN,
  output logic [9:0]                  oX,
  output logic [9:0]                  oY,
  output logic                        oACTIVE,
  output logic                        oFRAME_START,
  output logic                        oVBLANK,
  output logic                        oRED,
  output logic                        oGREEN,
  output logic                        oBLUE,
  output logic                        oHSYNC,
  output logic                        oVSYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  // Sync window bounds kept 11 bits wide so a zero back porch cannot truncate to 0.
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_IDLE = (SYNC_NEG != 0);

  logic [3:0] div;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       tick;
  logic       hs_on;
  logic       vs_on;
  rgb_t       mux_rgb;

  assign tick    = iENABLE && (div == DIV_LAST);
  assign oVBLANK = (vcnt >= V_VIS);

  // oX/oY still hold the previous coordinate at the strobe, which is what the pins show next.
  assign hs_on = ({1'b0, oX} >= HS_START) && ({1'b0, oX} < HS_END);
  assign vs_on = ({1'b0, oY} >= VS_START) && ({1'b0, oY} < VS_END);

  vga_layer_mux #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_mux (
    .layer_valid(iLAYER_VALID),
    .layer_rgb  (iLAYER_RGB),
    .bg_rgb     (iBG_RGB),
    .active     (oACTIVE),
    .pix_rgb    (mux_rgb)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      div                    <= '0;
      hcnt                   <= '0;
      vcnt                   <= '0;
      oPIX_EN                <= 1'b0;
      oFRAME_START           <= 1'b0;
      oX                     <= '0;
      oY                     <= '0;
      oACTIVE                <= 1'b0;
      {oRED, oGREEN, oBLUE}  <= '0;
      oHSYNC                 <= SYNC_IDLE;
      oVSYNC                 <= SYNC_IDLE;
    end else if (!iENABLE) begin
      div                    <= '0;
      hcnt                   <= '0;
      vcnt                   <= '0;
      oPIX_EN                <= 1'b0;
      oFRAME_START           <= 1'b0;
      oX                     <= '0;
      oY                     <= '0;
      oACTIVE                <= 1'b0;
      {oRED, oGREEN, oBLUE}  <= '0;
      oHSYNC                 <= SYNC_IDLE;
      oVSYNC                 <= SYNC_IDLE;
    end else begin
      oPIX_EN      <= tick;
      oFRAME_START <= tick && (hcnt == '0) && (vcnt == '0);
      div          <= tick ? '0 : div + 4'd1;
      if (tick) begin
        oX                    <= hcnt;
        oY                    <= vcnt;
        oACTIVE               <= (hcnt < H_VIS) && (vcnt < V_VIS);
        {oRED, oGREEN, oBLUE} <= mux_rgb;
        oHSYNC                <= hs_on ^ SYNC_IDLE;
        oVSYNC                <= vs_on ^ SYNC_IDLE;
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// Bench for vga_layer_scheduler on a shrunken raster; per-cycle scoreboard derived
// from strobe-count arithmetic, plus priority table and enable/reset sequences.
module tb_vga_layer_scheduler;
  localparam int CD = 5;
  localparam int NL = 4;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  typedef struct packed {
    logic       pix;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       fs;
    logic       vblank;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } obs_t;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] rgb;
    logic [2:0]  bg;
    bit          blank;
    logic [2:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [2:0]  bg = '0;
  logic [3:0]  lv = '0;
  logic [11:0] lrgb = '0;
  logic        pix_en, active, fstart, vblank, red, green, blue, hsync, vsync;
  logic [9:0]  ox, oy;

  int   errors = 0;
  int   checks = 0;
  int   n_en = 0;
  obs_t exp_o;

  always #5 clk = ~clk;

  vga_layer_scheduler #(
    .CLK_DIV(CD), .NUM_LAYERS(NL),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_NEG(1)
  ) dut (
    .iCLK(clk), .iRESET(rst), .iENABLE(ena), .iBG_RGB(bg),
    .iLAYER_VALID(lv), .iLAYER_RGB(lrgb),
    .oPIX_EN(pix_en), .oX(ox), .oY(oy), .oACTIVE(active),
    .oFRAME_START(fstart), .oVBLANK(vblank),
    .oRED(red), .oGREEN(green), .oBLUE(blue),
    .oHSYNC(hsync), .oVSYNC(vsync)
  );

  function automatic obs_t observed();
    obs_t o;
    o.pix = pix_en; o.x = ox; o.y = oy; o.active = active; o.fs = fstart;
    o.vblank = vblank; o.rgb = {red, green, blue}; o.hs = hsync; o.vs = vsync;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic logic [2:0] pick(logic [3:0] v, logic [11:0] c, logic [2:0] b);
    int n;
    n = 0;
    while (n < NL && !v[n]) n++;
    return (n == NL) ? b : c[3*n +: 3];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Strobe s is the s-th pixel since enable; its pins describe pixel s-1.
  task automatic model_edge();
    int s, px, py;
    if (rst || !ena) begin
      n_en  = 0;
      exp_o = idle_obs();
    end else begin
      n_en++;
      exp_o.pix = (n_en % CD == 0);
      exp_o.fs  = 1'b0;
      if (exp_o.pix) begin
        s = n_en / CD - 1;
        if (s == 0) begin
          exp_o.rgb = 3'b000; exp_o.hs = 1'b1; exp_o.vs = 1'b1;
        end else begin
          px = (s - 1) % HT;
          py = ((s - 1) / HT) % VT;
          exp_o.rgb = (px < HA && py < VA) ? pick(lv, lrgb, bg) : 3'b000;
          exp_o.hs  = !(px >= HA + HFP && px < HA + HFP + HS);
          exp_o.vs  = !(py >= VA + VFP && py < VA + VFP + VS);
        end
        exp_o.x      = 10'(s % HT);
        exp_o.y      = 10'((s / HT) % VT);
        exp_o.active = (s % HT < HA) && ((s / HT) % VT < VA);
        exp_o.fs     = (s % (HT * VT) == 0);
      end
      exp_o.vblank = (((n_en / CD) / HT) % VT >= VA);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", 64'(observed()), 64'(exp_o));
  endtask

  task automatic wait_pix(output int clks, output bit ok);
    clks = 0;
    ok = 1'b0;
    for (int i = 0; i < 4 * CD; i++) begin
      tick();
      clks++;
      if (pix_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_pix");
  endtask

  task automatic wait_coord(input bit blank, input int tx, input int ty, input bit any, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * HT * VT * CD; i++) begin
      tick();
      if (pix_en && (any ? (blank ? (oy < VA && ox >= HA) : active)
                         : (int'(ox) == tx && int'(oy) == ty))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_coord");
  endtask

  initial begin
    vec_t vecs[6];
    int   c, cnt, hs_low, vs_low, vb_high;
    bit   ok;

    vecs[0] = '{4'b0101, {3'b000, 3'b011, 3'b000, 3'b100}, 3'b000, 1'b0, 3'b100};
    vecs[1] = '{4'b0100, {3'b000, 3'b011, 3'b000, 3'b100}, 3'b000, 1'b0, 3'b011};
    vecs[2] = '{4'b0000, {3'b111, 3'b111, 3'b111, 3'b111}, 3'b001, 1'b0, 3'b001};
    vecs[3] = '{4'b1000, {3'b110, 3'b000, 3'b000, 3'b000}, 3'b101, 1'b0, 3'b110};
    vecs[4] = '{4'b1010, {3'b111, 3'b000, 3'b010, 3'b000}, 3'b100, 1'b0, 3'b010};
    vecs[5] = '{4'b1111, {3'b111, 3'b111, 3'b111, 3'b111}, 3'b111, 1'b1, 3'b000};

    exp_o = idle_obs();
    repeat (3) tick();
    chk("reset_state", 64'(observed()), 64'(idle_obs()));

    // Power-up run: strobe cadence, frame length and sync/blank duty over one frame.
    rst = 1'b0;
    ena = 1'b1;
    wait_pix(c, ok);
    chk("first_pix_latency", 64'(c), 64'(CD));
    chk("first_frame_start", 64'(fstart), 64'd1);
    chk("first_xy", 64'({ox, oy}), 64'd0);
    wait_pix(c, ok);
    chk("pix_period", 64'(c), 64'(CD));
    cnt = 1; hs_low = 0; vs_low = 0; vb_high = 0;
    while (cnt <= HT * VT) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (vblank) vb_high++;
      wait_pix(c, ok);
      if (!ok) break;
      cnt++;
      if (fstart) break;
    end
    chk("frame_strobes", 64'(cnt), 64'(HT * VT));
    chk("hsync_low_per_frame", 64'(hs_low), 64'(HS * VT));
    chk("vsync_low_per_frame", 64'(vs_low), 64'(VS * HT));
    chk("vblank_per_frame", 64'(vb_high), 64'((VT - VA) * HT));

    // Priority table: inputs held for a whole pixel, result seen one strobe later.
    foreach (vecs[i]) begin
      lv = vecs[i].valid; lrgb = vecs[i].rgb; bg = vecs[i].bg;
      wait_coord(vecs[i].blank, 0, 0, 1'b1, ok);
      wait_pix(c, ok);
      chk($sformatf("layer_vec%0d", i), 64'({red, green, blue}), 64'(vecs[i].exp));
    end

    // Mid-line disable, hold, re-enable from the origin.
    lv = 4'b0001; lrgb = 12'h007; bg = 3'b010;
    wait_coord(1'b0, 8, 3, 1'b0, ok);
    ena = 1'b0;
    tick();
    chk("disable_rgb", 64'({red, green, blue}), 64'd0);
    chk("disable_syncs", 64'({hsync, vsync}), 64'b11);
    repeat (9) tick();
    ena = 1'b1;
    wait_pix(c, ok);
    chk("reenable_latency", 64'(c), 64'(CD));
    chk("reenable_xy", 64'({ox, oy}), 64'd0);
    chk("reenable_frame_start", 64'(fstart), 64'd1);

    // Random layers/background with occasional enable drops over about two frames.
    for (int i = 0; i < 2 * HT * VT * CD + 200; i++) begin
      lv   = 4'($urandom);
      lrgb = 12'($urandom);
      bg   = 3'($urandom);
      ena  = ($urandom_range(0, 599) != 0);
      tick();
    end
    ena = 1'b1;

    // Asynchronous reset between clock edges.
    wait_coord(1'b0, 0, 0, 1'b1, ok);
    #3 rst = 1'b1;
    #1 chk("async_reset", 64'(observed()), 64'(idle_obs()));
    n_en  = 0;
    exp_o = idle_obs();
    tick();
    tick();
    #2 rst = 1'b0;
    wait_pix(c, ok);
    chk("post_reset_latency", 64'(c), 64'(CD));
    chk("post_reset_frame_start", 64'({fstart, ox, oy}), 64'({1'b1, 20'd0}));
    wait_pix(c, ok);
    chk("post_reset_period", 64'(c), 64'(CD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
